// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
// Operation encodings follow funct3 directly.
package muldiv_pkg;

   localparam int MD_XLEN = 32;
   localparam int MD_ITER = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } md_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } md_state_t;

   function automatic logic is_div(input md_op_t op);
      return op[2];
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply (shift-add) / divide (restoring).
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiply.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            md_start,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] md_op1,
   input  logic [XLEN-1:0] md_op2,
   input  logic            md_flush,
   output logic            md_busy,
   output logic            md_done,
   output logic [XLEN-1:0] md_result
);

   md_state_t       r_state;
   md_op_t          r_op;
   logic            r_neg;
   logic [4:0]      r_cnt;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_b;
   logic            r_busy;
   logic            r_done;
   logic [XLEN-1:0] r_result;

   md_op_t          w_op;
   logic            w_sg1, w_sg2, w_s1, w_s2, w_neg;
   logic [XLEN-1:0] w_mag1, w_mag2;
   logic            w_spec;
   logic [XLEN-1:0] w_spec_res;
   logic            w_div;
   logic [XLEN:0]   w_remsh, w_a, w_b, w_sum;
   logic [XLEN-1:0] w_hi_nx, w_lo_nx, w_res;
   logic [2*XLEN-1:0] w_prod, w_prod_n;

   assign w_op = md_op_t'(md_op);

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*XLEN-1:0] w_fast;
   assign w_fast = (2*XLEN)'($signed({w_s1, md_op1}) * $signed({w_s2, md_op2}));
`endif

   always_comb begin
      w_sg1 = !(w_op == OP_MULHU || w_op == OP_DIVU || w_op == OP_REMU);
      w_sg2 = (w_op == OP_MUL || w_op == OP_MULH ||
               w_op == OP_DIV || w_op == OP_REM);
      w_s1 = w_sg1 & md_op1[XLEN-1];
      w_s2 = w_sg2 & md_op2[XLEN-1];
      w_mag1 = w_s1 ? -md_op1 : md_op1;
      w_mag2 = w_s2 ? -md_op2 : md_op2;
      // Remainder takes the dividend's sign; everything else XORs
      w_neg = (w_op == OP_REM || w_op == OP_REMU) ? w_s1 : (w_s1 ^ w_s2);
      w_spec = 1'b0;
      w_spec_res = '0;
      if (is_div(w_op) && md_op2 == '0) begin
         w_spec = 1'b1;
         w_spec_res = w_op[1] ? md_op1 : '1;
      end else if ((w_op == OP_DIV || w_op == OP_REM) &&
                   md_op1 == {1'b1, {(XLEN-1){1'b0}}} && md_op2 == '1) begin
         w_spec = 1'b1;
         w_spec_res = w_op[1] ? '0 : md_op1;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (!is_div(w_op)) begin
         w_spec = 1'b1;
         w_spec_res = (w_op == OP_MUL) ? w_fast[XLEN-1:0]
                                       : w_fast[2*XLEN-1:XLEN];
      end
`endif
   end

   // Shared adder: add multiplicand for multiply, subtract divisor for divide
   always_comb begin
      w_div = is_div(r_op);
      w_remsh = {r_hi, r_lo[XLEN-1]};
      w_a = w_div ? w_remsh : {1'b0, r_hi};
      w_b = (w_div | r_lo[0]) ? {1'b0, r_b} : '0;
      w_sum = w_div ? (w_a - w_b) : (w_a + w_b);
      if (w_div) begin
         w_hi_nx = w_sum[XLEN] ? w_remsh[XLEN-1:0] : w_sum[XLEN-1:0];
         w_lo_nx = {r_lo[XLEN-2:0], !w_sum[XLEN]};
      end else begin
         w_hi_nx = w_sum[XLEN:1];
         w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
      end
      w_prod = {w_hi_nx, w_lo_nx};
      w_prod_n = r_neg ? -w_prod : w_prod;
      unique case (r_op)
         OP_MUL:                      w_res = w_prod_n[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_prod_n[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             w_res = r_neg ? -w_lo_nx : w_lo_nx;
         default:                     w_res = r_neg ? -w_hi_nx : w_hi_nx;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= OP_MUL;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (md_start && !md_flush) begin
                  r_op   <= w_op;
                  r_neg  <= w_neg;
                  r_cnt  <= '0;
                  r_hi   <= '0;
                  r_busy <= 1'b1;
                  r_lo   <= is_div(w_op) ? w_mag1 : w_mag2;
                  r_b    <= is_div(w_op) ? w_mag2 : w_mag1;
                  if (w_spec) begin
                     r_state  <= S_DONE;
                     r_done   <= 1'b1;
                     r_result <= w_spec_res;
                  end else begin
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (md_flush) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_hi  <= w_hi_nx;
                  r_lo  <= w_lo_nx;
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'(MD_ITER - 1)) begin
                     r_state  <= S_DONE;
                     r_done   <= 1'b1;
                     r_result <= w_res;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign md_busy   = r_busy;
   assign md_done   = r_done;
   assign md_result = r_result;

endmodule
